mem_stage_ctrl: RTL and testbench

Memory-stage controller that sits directly upstream of the data memory. It accepts load/store requests from the execute stage over a valid/ready handshake and decodes RISC-V funct3 into the data memory's 4-bit mem_en code. It drives the address and store-data buses for exactly one cycle, captures load data, and hands loads and faults to writeback over a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_req_decode.sv | 58 +++++
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 values, data-memory
// mem_en codes and the controller state type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bit 3 requests sign extension from the data memory.
    localparam logic [3:0] MEM_IDLE   = 4'b0000;
    localparam logic [3:0] MEM_LB     = 4'b0001;
    localparam logic [3:0] MEM_LH     = 4'b0010;
    localparam logic [3:0] MEM_LW     = 4'b0011;
    localparam logic [3:0] MEM_SB     = 4'b0101;
    localparam logic [3:0] MEM_SH     = 4'b0110;
    localparam logic [3:0] MEM_SW     = 4'b0111;
    localparam logic [3:0] MEM_SIGNED = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_req_decode.sv
// Combinational request decode: funct3/direction/address to mem_en code,
// access size in bytes and a fault flag (illegal funct3 or out of range).
module mem_req_decode
    import mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] addr_i,
    output logic [3:0]  mem_en_o,
    output logic [2:0]  size_o,
    output logic        fault_o
);

    logic        illegal;
    logic        out_of_range;
    logic [3:0]  code;
    logic [32:0] last_byte;

    always_comb begin
        illegal = 1'b0;
        size_o  = 3'd1;
        code    = MEM_IDLE;
        case (funct3_i[1:0])
            2'b00:   size_o = 3'd1;
            2'b01:   size_o = 3'd2;
            2'b10:   size_o = 3'd4;
            default: illegal = 1'b1;
        endcase
        if (is_store_i) begin
            if (funct3_i[2]) begin
                illegal = 1'b1;
            end
            case (funct3_i[1:0])
                2'b00:   code = MEM_SB;
                2'b01:   code = MEM_SH;
                default: code = MEM_SW;
            endcase
        end else begin
            case (funct3_i)
                F3_B:    code = MEM_LB | MEM_SIGNED;
                F3_H:    code = MEM_LH | MEM_SIGNED;
                F3_W:    code = MEM_LW;
                F3_BU:   code = MEM_LB;
                F3_HU:   code = MEM_LH;
                default: illegal = 1'b1;
            endcase
        end
    end

    // Computed in 33 bits so an access straddling 2^32 is still caught.
    assign last_byte    = {1'b0, addr_i} + {30'd0, size_o} - 33'd1;
    assign out_of_range = |last_byte[32:MEM_ADDR_BITS];
    assign fault_o      = illegal | out_of_range;
    assign mem_en_o     = fault_o ? MEM_IDLE : code;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: accepts load/store requests, drives the data
// memory for one cycle, captures load data and returns loads/faults.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_is_store_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [4:0]           req_rd_i,
    output logic [3:0]           mem_en_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [31:0]          resp_data_o,
    output logic [4:0]           resp_rd_o,
    output logic                 resp_fault_o,
    output logic [CNT_WIDTH-1:0] load_cnt_o,
    output logic [CNT_WIDTH-1:0] store_cnt_o
);

    state_e               state_q;
    logic                 req_ready_q;
    logic                 is_store_q;
    logic [4:0]           rd_q;
    logic [3:0]           mem_en_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_wdata_q;
    logic                 resp_valid_q;
    logic [31:0]          resp_data_q;
    logic [4:0]           resp_rd_q;
    logic                 resp_fault_q;
    logic [CNT_WIDTH-1:0] load_cnt_q;
    logic [CNT_WIDTH-1:0] load_cnt_d;
    logic [CNT_WIDTH-1:0] store_cnt_q;
    logic [CNT_WIDTH-1:0] store_cnt_d;

    logic [3:0]           dec_mem_en;
    logic [2:0]           dec_size;
    logic                 dec_fault;

    mem_req_decode #(
        .MEM_ADDR_BITS(MEM_ADDR_BITS)
    ) u_decode (
        .funct3_i  (req_funct3_i),
        .is_store_i(req_is_store_i),
        .addr_i    (req_addr_i),
        .mem_en_o  (dec_mem_en),
        .size_o    (dec_size),
        .fault_o   (dec_fault)
    );

    assign load_cnt_d  = load_cnt_q + 1'b1;
    assign store_cnt_d = store_cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            is_store_q   <= 1'b0;
            rd_q         <= 5'd0;
            mem_en_q     <= MEM_IDLE;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_fault_q <= 1'b0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_q <= 1'b0;
                        is_store_q  <= req_is_store_i;
                        rd_q        <= req_rd_i;
                        // Faults never touch the memory; they go straight to the response.
                        if (dec_fault) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_data_q  <= 32'd0;
                            resp_rd_q    <= req_is_store_i ? 5'd0 : req_rd_i;
                        end else begin
                            state_q     <= ST_ISSUE;
                            mem_en_q    <= dec_mem_en;
                            mem_addr_q  <= req_addr_i;
                            mem_wdata_q <= req_is_store_i ? req_wdata_i : 32'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_en_q    <= MEM_IDLE;
                    mem_addr_q  <= 32'd0;
                    mem_wdata_q <= 32'd0;
                    if (is_store_q) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        store_cnt_q <= store_cnt_d;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= mem_rdata_i;
                    resp_rd_q    <= rd_q;
                    resp_fault_q <= 1'b0;
                    load_cnt_q   <= load_cnt_d;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= 32'd0;
                        resp_rd_q    <= 5'd0;
                        resp_fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign mem_en_o     = mem_en_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_rd_o    = resp_rd_q;
    assign resp_fault_o = resp_fault_q;
    assign load_cnt_o   = load_cnt_q;
    assign store_cnt_o  = store_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl with a byte-array data memory and a
// byte-level reference model of loads, stores and faults.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqIsStore;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [4:0]  reqRd;
    logic [3:0]  memEn;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic [4:0]  respRd;
    logic        respFault;
    logic [15:0] loadCnt;
    logic [15:0] storeCnt;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        int          expCyc;
    } resp_t;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        isStore;
    } issue_t;

    resp_t       respQ[$];
    issue_t      issueQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          expLoads = 0;
    int          expStores = 0;
    int          rrMode = 0;
    bit          started = 1'b0;
    bit          respSeen = 1'b0;
    bit          memInit = 1'b0;
    logic [7:0]  refMem [0:4095];
    logic [7:0]  dmem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_stage_ctrl #(
        .MEM_ADDR_BITS(12),
        .CNT_WIDTH(16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (reqValid),
        .req_ready_o   (reqReady),
        .req_is_store_i(reqIsStore),
        .req_funct3_i  (reqFunct3),
        .req_addr_i    (reqAddr),
        .req_wdata_i   (reqWdata),
        .req_rd_i      (reqRd),
        .mem_en_o      (memEn),
        .mem_addr_o    (memAddr),
        .mem_wdata_o   (memWdata),
        .mem_rdata_i   (memRdata),
        .resp_valid_o  (respValid),
        .resp_ready_i  (respReady),
        .resp_data_o   (respData),
        .resp_rd_o     (respRd),
        .resp_fault_o  (respFault),
        .load_cnt_o    (loadCnt),
        .store_cnt_o   (storeCnt)
    );

    // Data memory: samples mem_en on the rising edge, read data is valid one cycle later.
    int          mNb;
    logic [31:0] mRaw;
    logic [11:0] mA;
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 4096; i++) dmem[i] = 8'h00;
            memInit = 1'b1;
        end
        if (memEn[2:0] != 3'b000) begin
            mNb = (memEn[1:0] == 2'b01) ? 1 : (memEn[1:0] == 2'b10) ? 2 : 4;
            mA  = memAddr[11:0];
            if (memEn[2]) begin
                for (int i = 0; i < mNb; i++) dmem[mA + 12'(i)] = memWdata[8*i +: 8];
            end else begin
                mRaw = 32'd0;
                for (int i = 0; i < mNb; i++) mRaw[8*i +: 8] = dmem[mA + 12'(i)];
                if (memEn[3] && mNb == 1)      memRdata <= {{24{mRaw[7]}}, mRaw[7:0]};
                else if (memEn[3] && mNb == 2) memRdata <= {{16{mRaw[15]}}, mRaw[15:0]};
                else                           memRdata <= mRaw;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: computes fault/code/data from the access rules on a byte array.
    task automatic applyStimulus(input bit isStore, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd);
        int          size;
        bit          illegal;
        bit          fault;
        logic [63:0] last;
        logic [3:0]  en;
        logic [31:0] raw;
        logic [31:0] val;
        resp_t       r;
        issue_t      is;
        int          n;

        @(negedge clk);
        n = 0;
        while (reqReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (reqReady !== 1'b1) begin
            checkOutput("req_ready_timeout", {31'd0, reqReady}, 32'd1);
            return;
        end

        illegal = 1'b0;
        size    = 1;
        en      = 4'b0000;
        val     = 32'd0;
        if (isStore) begin
            case (f3)
                3'd0:    begin size = 1; en = 4'b0101; end
                3'd1:    begin size = 2; en = 4'b0110; end
                3'd2:    begin size = 4; en = 4'b0111; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0:    begin size = 1; en = 4'b1001; end
                3'd1:    begin size = 2; en = 4'b1010; end
                3'd2:    begin size = 4; en = 4'b0011; end
                3'd4:    begin size = 1; en = 4'b0001; end
                3'd5:    begin size = 2; en = 4'b0010; end
                default: illegal = 1'b1;
            endcase
        end
        last  = 64'(addr) + 64'(size) - 64'd1;
        fault = illegal || (last >= 64'd4096);

        if (fault) begin
            r.data = 32'd0; r.rd = isStore ? 5'd0 : rd; r.fault = 1'b1; r.expCyc = cyc + 1;
            respQ.push_back(r);
        end else begin
            is.en = en; is.addr = addr; is.wdata = wdata; is.isStore = isStore;
            issueQ.push_back(is);
            if (isStore) begin
                for (int i = 0; i < size; i++) refMem[addr[11:0] + 12'(i)] = wdata[8*i +: 8];
                expStores++;
            end else begin
                raw = 32'd0;
                for (int i = 0; i < size; i++) raw[8*i +: 8] = refMem[addr[11:0] + 12'(i)];
                case (f3)
                    3'd0:    val = {{24{raw[7]}}, raw[7:0]};
                    3'd1:    val = {{16{raw[15]}}, raw[15:0]};
                    3'd4:    val = {24'd0, raw[7:0]};
                    3'd5:    val = {16'd0, raw[15:0]};
                    default: val = raw;
                endcase
                r.data = val; r.rd = rd; r.fault = 1'b0; r.expCyc = cyc + 3;
                respQ.push_back(r);
                expLoads++;
            end
        end

        reqValid   = 1'b1;
        reqIsStore = isStore;
        reqFunct3  = f3;
        reqAddr    = addr;
        reqWdata   = wdata;
        reqRd      = rd;
        @(posedge clk);
        #1 reqValid = 1'b0;
        reqWdata = $urandom;

        if (isStore && !fault) begin
            @(negedge clk);
            checkOutput("store_busy_after_accept", {31'd0, reqReady}, 32'd0);
            @(negedge clk);
            checkOutput("store_ready_after_2_edges", {31'd0, reqReady}, 32'd1);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic waitIdleCheckCounters(input string tag);
        int n;
        n = 0;
        while ((reqReady !== 1'b1 || respQ.size() != 0 || issueQ.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_pending_resp"}, respQ.size(), 32'd0);
        checkOutput({tag, "_pending_issue"}, issueQ.size(), 32'd0);
        checkOutput({tag, "_load_cnt"}, {16'd0, loadCnt}, expLoads & 32'hFFFF);
        checkOutput({tag, "_store_cnt"}, {16'd0, storeCnt}, expStores & 32'hFFFF);
    endtask

    // Monitor: pops issue records on memory activity and responses on handshakes.
    issue_t monIs;
    resp_t  monR;
    always @(negedge clk) begin
        if (started && rst === 1'b0) begin
            if (memEn !== 4'b0000) begin
                if (issueQ.size() == 0) begin
                    checkOutput("unexpected_mem_en", {28'd0, memEn}, 32'd0);
                end else begin
                    monIs = issueQ.pop_front();
                    checkOutput("mem_en", {28'd0, memEn}, {28'd0, monIs.en});
                    checkOutput("mem_addr", memAddr, monIs.addr);
                    if (monIs.isStore) checkOutput("mem_wdata", memWdata, monIs.wdata);
                end
            end
            if (respValid === 1'b1) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpected_resp_valid", {31'd0, respValid}, 32'd0);
                end else begin
                    monR = respQ[0];
                    if (!respSeen) begin
                        checkOutput("resp_latency_cycle", cyc, monR.expCyc);
                        respSeen = 1'b1;
                    end
                    checkOutput("resp_data", respData, monR.data);
                    checkOutput("resp_rd", {27'd0, respRd}, {27'd0, monR.rd});
                    checkOutput("resp_fault", {31'd0, respFault}, {31'd0, monR.fault});
                    if (respReady === 1'b1) begin
                        void'(respQ.pop_front());
                        respSeen = 1'b0;
                    end else begin
                        checkOutput("req_ready_in_resp", {31'd0, reqReady}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        respReady = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rrMode)
                0:       respReady = 1'($urandom_range(0, 1));
                1:       respReady = 1'b0;
                default: respReady = 1'b1;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;

        for (int i = 0; i < 4096; i++) refMem[i] = 8'h00;
        rst = 1'b1; reqValid = 1'b0; reqIsStore = 1'b0; reqFunct3 = 3'd0;
        reqAddr = 32'd0; reqWdata = 32'd0; reqRd = 5'd0;

        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("reset_mem_en", {28'd0, memEn}, 32'd0);
        checkOutput("reset_mem_addr", memAddr, 32'd0);
        checkOutput("reset_mem_wdata", memWdata, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, respValid}, 32'd0);
        checkOutput("reset_resp_data", respData, 32'd0);
        checkOutput("reset_counters", {loadCnt, storeCnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;

        applyStimulus(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 5'd0);
        applyStimulus(1'b0, 3'd2, 32'h010, 32'd0, 5'd5);
        waitIdleCheckCounters("sw_lw");

        applyStimulus(1'b1, 3'd0, 32'h013, 32'h12345680, 5'd0);
        applyStimulus(1'b0, 3'd0, 32'h013, 32'd0, 5'd6);
        applyStimulus(1'b0, 3'd4, 32'h013, 32'd0, 5'd7);
        applyStimulus(1'b1, 3'd2, 32'h0FE, 32'h11223344, 5'd0);
        applyStimulus(1'b0, 3'd5, 32'h0FF, 32'd0, 5'd8);
        waitIdleCheckCounters("byte_half");

        applyStimulus(1'b0, 3'd2, 32'hFFD, 32'd0, 5'd9);
        applyStimulus(1'b0, 3'd2, 32'hFFC, 32'd0, 5'd10);
        applyStimulus(1'b0, 3'd0, 32'h1000, 32'd0, 5'd11);
        applyStimulus(1'b0, 3'd3, 32'h020, 32'd0, 5'd12);
        applyStimulus(1'b1, 3'd4, 32'h020, 32'hCAFEF00D, 5'd13);
        applyStimulus(1'b1, 3'd2, 32'hFFFFFFFE, 32'h0BADF00D, 5'd14);
        waitIdleCheckCounters("faults");

        rrMode = 1;
        @(negedge clk);
        applyStimulus(1'b0, 3'd2, 32'h010, 32'd0, 5'd17);
        n = 0;
        while (respValid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("backpressure_resp_valid", {31'd0, respValid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("backpressure_hold_valid", {31'd0, respValid}, 32'd1);
            checkOutput("backpressure_hold_ready", {31'd0, reqReady}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        respQ.delete();
        issueQ.delete();
        respSeen = 1'b0;
        expLoads = 0;
        expStores = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_resp_valid", {31'd0, respValid}, 32'd0);
        checkOutput("post_reset_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("post_reset_counters", {loadCnt, storeCnt}, 32'd0);
        checkOutput("post_reset_resp_data", respData, 32'd0);
        rrMode = 0;

        for (int k = 0; k < 300; k++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = st ? 3'd0 : 3'd4;
                    default: f3 = st ? 3'd1 : 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 5))
                0, 1, 2: a = $urandom_range(0, 4095);
                3:       a = $urandom_range(0, 15) + 32'h100;
                4:       a = $urandom_range(4088, 4100);
                default: a = $urandom;
            endcase
            applyStimulus(st, f3, a, $urandom, 5'($urandom_range(0, 31)));
        end
        waitIdleCheckCounters("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
